// File: rtl/sigma_pkg.sv
// sigma_pkg: opcodes, FSM states, CC bit positions and IR field helpers for sigma_cpu
package sigma_pkg;
    localparam logic [6:0] OP_AI  = 7'h20;
    localparam logic [6:0] OP_LI  = 7'h22;
    localparam logic [6:0] OP_AW  = 7'h30;
    localparam logic [6:0] OP_LW  = 7'h32;
    localparam logic [6:0] OP_BCR = 7'h68;
    localparam logic [6:0] OP_BCS = 7'h69;
    localparam int CC1 = 3;
    localparam int CC2 = 2;
    localparam int CC3 = 1;
    localparam int CC4 = 0;
    typedef enum logic [1:0] {S_FETCH, S_INDIRECT, S_EXEC} state_e;
    // Sigma numbers bits big-endian: IR[0] is the MSB, so IR[n] maps to ir[31-n]
    function automatic logic ir_i(input logic [31:0] ir);
        return ir[31];
    endfunction
    function automatic logic [6:0] ir_op(input logic [31:0] ir);
        return ir[30:24];
    endfunction
    function automatic logic [3:0] ir_r(input logic [31:0] ir);
        return ir[23:20];
    endfunction
    function automatic logic [2:0] ir_x(input logic [31:0] ir);
        return ir[19:17];
    endfunction
    function automatic logic [16:0] ir_addr(input logic [31:0] ir);
        return ir[16:0];
    endfunction
    function automatic logic [31:0] ir_imm(input logic [31:0] ir);
        return {{12{ir[19]}}, ir[19:0]};
    endfunction
    function automatic logic is_memref(input logic [6:0] op);
        return op inside {OP_AW, OP_LW, OP_BCR, OP_BCS};
    endfunction
endpackage

// File: rtl/sigma_if.sv
// sigma_if: word-address / read-data bus between sigma_cpu and a combinational-read memory
interface sigma_if;
    logic [16:0] address;
    logic [31:0] data_in;
    modport master (output address, input data_in);
    modport slave (input address, output data_in);
endinterface

// File: rtl/sigma_alu.sv
// sigma_alu: 32-bit add-or-pass with carry, signed overflow and CC3/CC4 sign flags
module sigma_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add,
    output logic [31:0] y,
    output logic        carry,
    output logic        ovf,
    output logic        gt,
    output logic        lt
);
    logic [32:0] sum;
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        y = add ? sum[31:0] : b;
        carry = sum[32];
        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
        gt = (y != 32'd0) && !y[31];
        lt = y[31];
    end
endmodule

// File: rtl/sigma_cpu.sv
// sigma_cpu: read-only Sigma subset core, FETCH/INDIRECT/EXEC with 16x32 register file
module sigma_cpu
    import sigma_pkg::*;
#(
    parameter logic [16:0] RESET_PC = 17'h00000
) (
    input  logic clock,
    input  logic reset,
    sigma_if.master bus
);
    state_e state_q, state_d;
    logic [16:0] q_q, q_d, ind_q, ind_d, ea;
    logic [31:0] ir_q, ir_d;
    logic [3:0] cc_q, cc_d;
    logic [31:0] r_q [16];
    logic [31:0] alu_b, alu_y;
    logic [6:0] op;
    logic [3:0] rf;
    logic [2:0] xf;
    logic alu_add, alu_c, alu_v, alu_gt, alu_lt, wr_en, taken;
    assign op = ir_op(ir_q);
    assign rf = ir_r(ir_q);
    assign xf = ir_x(ir_q);
    // Indexing is applied after indirection; ind_q only matters when I was set on a memory-ref op
    assign ea = (ir_i(ir_q) ? ind_q : ir_addr(ir_q)) + (xf != 3'd0 ? r_q[{1'b0, xf}][16:0] : 17'd0);
    assign bus.address = state_q == S_FETCH ? q_q : state_q == S_INDIRECT ? ir_addr(ir_q) : ea;
    assign alu_add = op == OP_AI || op == OP_AW;
    assign alu_b = (op == OP_LI || op == OP_AI) ? ir_imm(ir_q) : bus.data_in;
    assign taken = op == OP_BCR ? (cc_q & rf) == 4'd0 : op == OP_BCS ? (cc_q & rf) != 4'd0 : 1'b0;
    sigma_alu u_alu (
        .a(r_q[rf]),
        .b(alu_b),
        .add(alu_add),
        .y(alu_y),
        .carry(alu_c),
        .ovf(alu_v),
        .gt(alu_gt),
        .lt(alu_lt)
    );
    always_comb begin
        state_d = state_q;
        q_d = q_q;
        ir_d = ir_q;
        ind_d = ind_q;
        cc_d = cc_q;
        wr_en = 1'b0;
        if (state_q == S_FETCH) begin
            ir_d = bus.data_in;
            q_d = q_q + 17'd1;
            state_d = (ir_i(bus.data_in) && is_memref(ir_op(bus.data_in))) ? S_INDIRECT : S_EXEC;
        end else if (state_q == S_INDIRECT) begin
            ind_d = bus.data_in[16:0];
            state_d = S_EXEC;
        end else begin
            state_d = S_FETCH;
            wr_en = op inside {OP_LI, OP_AI, OP_LW, OP_AW};
            q_d = taken ? ea : q_q;
            if (wr_en) begin
                cc_d[CC3] = alu_gt;
                cc_d[CC4] = alu_lt;
                cc_d[CC1] = alu_add ? alu_c : cc_q[CC1];
                cc_d[CC2] = alu_add ? alu_v : cc_q[CC2];
            end
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            q_q <= RESET_PC;
            ir_q <= '0;
            ind_q <= '0;
            cc_q <= '0;
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            q_q <= q_d;
            ir_q <= ir_d;
            ind_q <= ind_d;
            cc_q <= cc_d;
            if (wr_en) r_q[rf] <= alu_y;
        end
    end
endmodule

// File: tb/tb_sigma_cpu.sv
// tb_sigma_cpu: directed and random programs checked against an instruction-level ISA model
module tb_sigma_cpu;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [31:0] mem [0:131071];
    logic [31:0] m_r [16];
    logic [3:0] m_cc;
    logic [16:0] m_q;
    int n_tests = 0;
    int n_fail = 0;
    sigma_if bus();
    sigma_cpu #(.RESET_PC(17'h00000)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    assign bus.data_in = mem[bus.address];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick(input string tag, input bit care, input logic [16:0] exp);
        if (care) check(tag, 32'(bus.address), 32'(exp));
        @(posedge clock);
        #1;
    endtask
    task automatic model_reset();
        m_q = '0;
        m_cc = '0;
        foreach (m_r[i]) m_r[i] = '0;
    endtask
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_addr", 32'(bus.address), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_addr_hold", 32'(bus.address), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask
    // One whole instruction: checks the bus address each cycle, then the architectural state
    task automatic step();
        logic [31:0] w, opd, res;
        logic [6:0] op;
        logic [3:0] rf;
        logic [2:0] x;
        logic [16:0] base, ea;
        logic mref;
        longint u, s;
        w = mem[m_q];
        tick("fetch_addr", 1'b1, m_q);
        m_q = m_q + 17'd1;
        op = w[30:24];
        rf = w[23:20];
        x = w[19:17];
        mref = op == 7'h30 || op == 7'h32 || op == 7'h68 || op == 7'h69;
        base = w[16:0];
        if (mref && w[31]) begin
            tick("ind_addr", 1'b1, w[16:0]);
            base = mem[w[16:0]][16:0];
        end
        ea = base + (x != 3'd0 ? m_r[x][16:0] : 17'd0);
        tick("exec_addr", mref, ea);
        opd = (op == 7'h22 || op == 7'h20) ? {{12{w[19]}}, w[19:0]} : mem[ea];
        if (op == 7'h22 || op == 7'h32) begin
            res = opd;
            m_r[rf] = res;
            m_cc = {m_cc[3:2], $signed(res) > 0, $signed(res) < 0};
        end else if (op == 7'h20 || op == 7'h30) begin
            u = longint'(m_r[rf]) + longint'(opd);
            s = longint'($signed(m_r[rf])) + longint'($signed(opd));
            res = 32'(u);
            m_r[rf] = res;
            m_cc = {u[32], s != longint'($signed(res)), $signed(res) > 0, $signed(res) < 0};
        end else if (op == 7'h68) begin
            if ((m_cc & rf) == 4'd0) m_q = ea;
        end else if (op == 7'h69) begin
            if ((m_cc & rf) != 4'd0) m_q = ea;
        end
        check("q", 32'(dut.q_q), 32'(m_q));
        check("cc", 32'(dut.cc_q), 32'(m_cc));
        check("r", dut.r_q[rf], m_r[rf]);
    endtask
    function automatic logic [31:0] rand_insn();
        logic [6:0] ops [8];
        logic [6:0] op;
        logic [3:0] r;
        logic i;
        logic [2:0] x;
        logic [16:0] a;
        ops = '{7'h22, 7'h20, 7'h32, 7'h30, 7'h68, 7'h69, 7'h00, 7'h3F};
        op = ops[$urandom_range(0, 7)];
        r = 4'($urandom);
        i = 1'($urandom);
        if (op == 7'h22 || op == 7'h20) return {i, op, r, 20'($urandom)};
        if (op == 7'h32 || op == 7'h30) begin
            x = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            a = i ? 17'h208 + 17'($urandom_range(0, 7)) : 17'h100 + 17'($urandom_range(0, 63));
            return {i, op, r, x, a};
        end
        if (op == 7'h68 || op == 7'h69) begin
            a = i ? 17'h200 + 17'($urandom_range(0, 7)) : 17'($urandom_range(0, 63));
            return {i, op, r, 3'd0, a};
        end
        return {i, op, 24'($urandom)};
    endfunction
    initial begin
        // LI R1,5
        mem = '{default: 32'h0};
        mem[0] = 32'h22100005;
        do_reset();
        step();
        check("t2_r1", dut.r_q[1], 32'd5);
        check("t2_cc", 32'(dut.cc_q), 32'b0010);
        check("t2_addr", 32'(bus.address), 32'h1);
        // LI then LW of a negative word
        mem = '{default: 32'h0};
        mem[0] = 32'h22100001;
        mem[1] = 32'h32200040;
        mem[32'h40] = 32'hFFFFFFFF;
        do_reset();
        repeat (2) step();
        check("t3_r2", dut.r_q[2], 32'hFFFFFFFF);
        check("t3_cc4", 32'(dut.cc_q[0]), 32'h1);
        // signed overflow on AI
        mem = '{default: 32'h0};
        mem[0] = 32'h32100040;
        mem[1] = 32'h20100001;
        mem[32'h40] = 32'h7FFFFFFF;
        do_reset();
        repeat (2) step();
        check("t4_r1", dut.r_q[1], 32'h80000000);
        check("t4_cc", 32'(dut.cc_q), 32'b0101);
        // direct and indirect branch
        mem = '{default: 32'h0};
        mem[0] = 32'h68000010;
        do_reset();
        step();
        check("t5_addr", 32'(bus.address), 32'h10);
        mem[0] = 32'hE8000020;
        mem[32'h20] = 32'h00000030;
        do_reset();
        step();
        check("t5_ind_addr", 32'(bus.address), 32'h30);
        // program counter wrap at the top of the address space
        mem = '{default: 32'h0};
        mem[0] = 32'h6801FFFF;
        mem[32'h1FFFF] = 32'h22400003;
        do_reset();
        repeat (2) step();
        check("wrap_q", 32'(dut.q_q), 32'h0);
        check("wrap_r4", dut.r_q[4], 32'h3);
        // reset asserted during EXEC
        mem = '{default: 32'h0};
        mem[0] = 32'h22300007;
        mem[1] = 32'h22300009;
        do_reset();
        step();
        tick("t6_fetch", 1'b1, 17'h1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_addr", 32'(bus.address), 32'h0);
        @(posedge clock);
        #1;
        check("t6_r3", dut.r_q[3], 32'h0);
        check("t6_q", 32'(dut.q_q), 32'h0);
        check("t6_cc", 32'(dut.cc_q), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        step();
        check("t6_rerun_r3", dut.r_q[3], 32'h7);
        // random programs
        for (int k = 0; k < 4; k++) begin
            mem = '{default: 32'h0};
            for (int a = 0; a < 64; a++) mem[a] = rand_insn();
            for (int a = 32'h100; a < 32'h140; a++) mem[a] = $urandom;
            for (int a = 0; a < 8; a++) begin
                mem[32'h200 + a] = {15'($urandom), 17'($urandom_range(0, 63))};
                mem[32'h208 + a] = {15'($urandom), 17'h100 + 17'($urandom_range(0, 63))};
            end
            do_reset();
            for (int n = 0; n < 150; n++) step();
            for (int i = 0; i < 16; i++) check("rand_reg", dut.r_q[i], m_r[i]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
